frame_swap_scheduler: RTL and testbench

Sequences loading of one complete colour frame from the HPS word stream into the back half of the `led_band_controller` double-buffered colour memory. Once the frame is complete, it issues the `new_frame` swap on the next turn boundary, so a displayed frame never changes mid-revolution. It also serialises focus-control (FC) register writes into the same controller and pulses the synchronizer's `write_fc` strobe. It sits between the HPS bridge and `led_band_controller`/`synchronizer`.

---
 rtl/litspin_pkg.sv | 26 ++
 rtl/frame_swap_scheduler_tick_sync.sv | 26 ++
 rtl/frame_swap_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_frame_swap_scheduler.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/litspin_pkg.sv
// Shared types and sizing helpers for the LitSpin LED band datapath.
package litspin_pkg;

    typedef enum logic [2:0] {
        FSS_IDLE,
        FSS_LOAD,
        FSS_WAIT_TICK,
        FSS_SWAP,
        FSS_FC_WR,
        FSS_FC_STROBE
    } fss_state_t;

    typedef logic [47:0] fc_word_t;

    function automatic int unsigned calc_frame_words(input int unsigned rows,
                                                     input int unsigned angles,
                                                     input int unsigned bpc,
                                                     input int unsigned w_width);
        return (3 * bpc * rows * angles) / w_width;
    endfunction

    function automatic int unsigned calc_addr_w(input int unsigned frame_words);
        return $clog2(frame_words);
    endfunction

endpackage

// File: rtl/frame_swap_scheduler_tick_sync.sv
// Two-flop synchronizer for an asynchronous level, with a one-cycle rising-edge pulse.
module tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    // [0],[1]: metastability chain; [2]: previous synchronized level for edge detect
    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/frame_swap_scheduler.sv
// Loads one colour frame into the back buffer, swaps it on a turn boundary,
// and serialises focus-control register writes into the same controller.
module frame_swap_scheduler
    import litspin_pkg::*;
#(
    parameter int unsigned NB_LED_ROWS   = 32,
    parameter int unsigned NB_ANGLES     = 128,
    parameter int unsigned BIT_PER_COLOR = 8,
    parameter int unsigned W_DATA_WIDTH  = 128,
    parameter bit          SWAP_ON_TICK  = 1'b1,
    localparam int unsigned FRAME_WORDS  =
        calc_frame_words(NB_LED_ROWS, NB_ANGLES, BIT_PER_COLOR, W_DATA_WIDTH),
    localparam int unsigned ADDR_W       = calc_addr_w(FRAME_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    turn_tick,
    input  logic                    s_valid,
    input  logic                    s_sof,
    input  logic [W_DATA_WIDTH-1:0] s_data,
    output logic                    s_ready,
    input  logic                    fc_req,
    input  logic [47:0]             fc_data,
    input  logic                    fc_addr,
    output logic                    fc_ack,
    output logic [ADDR_W-1:0]       color_w_addr,
    output logic [W_DATA_WIDTH-1:0] color_w_data,
    output logic                    color_w_enable,
    output logic [47:0]             fc_w_data,
    output logic                    fc_w_addr,
    output logic                    fc_w_enable,
    output logic                    write_fc,
    output logic                    new_frame,
    output logic                    busy,
    output logic                    err_restart,
    output logic                    err_drop
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    fss_state_t              state_q, state_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic                    run_q;
    fc_word_t                fc_data_q, fc_data_d;
    logic                    fc_addr_q, fc_addr_d;
    logic                    color_we_q, color_we_d;
    logic [ADDR_W-1:0]       color_addr_q, color_addr_d;
    logic [W_DATA_WIDTH-1:0] color_data_q, color_data_d;
    logic                    new_frame_q, new_frame_d;
    logic                    err_restart_q, err_restart_d;
    logic                    err_drop_q, err_drop_d;
    logic                    tick_rise;
    logic                    xfer;
    logic                    fc_take;

    tick_sync u_tick_sync (
        .clk      (clk),
        .rst_n    (rst),
        .async_in (turn_tick),
        .rise     (tick_rise)
    );

    // run_q keeps s_ready low while reset is held and for the edge that releases it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FSS_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FSS_IDLE: begin
                if (fc_take) begin
                    state_d = FSS_FC_WR;
                end else if (xfer && s_sof) begin
                    state_d = FSS_LOAD;
                end
            end
            FSS_LOAD: begin
                if (xfer && !s_sof && cnt_q == LAST_ADDR) begin
                    state_d = SWAP_ON_TICK ? FSS_WAIT_TICK : FSS_SWAP;
                end
            end
            FSS_WAIT_TICK: begin
                if (tick_rise) begin
                    state_d = FSS_SWAP;
                end
            end
            FSS_SWAP:      state_d = FSS_IDLE;
            FSS_FC_WR:     state_d = FSS_FC_STROBE;
            FSS_FC_STROBE: state_d = FSS_IDLE;
            default:       state_d = FSS_IDLE;
        endcase
    end

    always_comb begin
        fc_take     = run_q && fc_req && (state_q == FSS_IDLE);
        s_ready     = run_q && ((state_q == FSS_LOAD) || (state_q == FSS_IDLE && !fc_req));
        xfer        = s_valid && s_ready;
        busy        = (state_q != FSS_IDLE);
        fc_ack      = (state_q == FSS_FC_WR);
        fc_w_enable = (state_q == FSS_FC_WR);
        write_fc    = (state_q == FSS_FC_STROBE);
    end

    // new_frame is registered off SWAP so it lands one cycle after the last write pulse
    always_comb begin
        cnt_d         = cnt_q;
        fc_data_d     = fc_data_q;
        fc_addr_d     = fc_addr_q;
        color_we_d    = 1'b0;
        color_addr_d  = color_addr_q;
        color_data_d  = color_data_q;
        new_frame_d   = (state_q == FSS_SWAP);
        err_restart_d = 1'b0;
        err_drop_d    = 1'b0;

        if (fc_take) begin
            fc_data_d = fc_data;
            fc_addr_d = fc_addr;
        end

        if (xfer) begin
            if (s_sof) begin
                color_we_d    = 1'b1;
                color_addr_d  = '0;
                color_data_d  = s_data;
                cnt_d         = ADDR_W'(1);
                err_restart_d = (state_q == FSS_LOAD);
            end else if (state_q == FSS_IDLE) begin
                err_drop_d = 1'b1;
            end else begin
                color_we_d   = 1'b1;
                color_addr_d = cnt_q;
                color_data_d = s_data;
                if (cnt_q != LAST_ADDR) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
        end

        if (state_q == FSS_SWAP) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            fc_data_q     <= '0;
            fc_addr_q     <= 1'b0;
            color_we_q    <= 1'b0;
            color_addr_q  <= '0;
            color_data_q  <= '0;
            new_frame_q   <= 1'b0;
            err_restart_q <= 1'b0;
            err_drop_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            fc_data_q     <= fc_data_d;
            fc_addr_q     <= fc_addr_d;
            color_we_q    <= color_we_d;
            color_addr_q  <= color_addr_d;
            color_data_q  <= color_data_d;
            new_frame_q   <= new_frame_d;
            err_restart_q <= err_restart_d;
            err_drop_q    <= err_drop_d;
        end
    end

    assign color_w_enable = color_we_q;
    assign color_w_addr   = color_addr_q;
    assign color_w_data   = color_data_q;
    assign fc_w_data      = fc_data_q;
    assign fc_w_addr      = fc_addr_q;
    assign new_frame      = new_frame_q;
    assign err_restart    = err_restart_q;
    assign err_drop       = err_drop_q;

endmodule

// File: tb/tb_frame_swap_scheduler.sv
// Directed bench for frame_swap_scheduler: default build plus a SWAP_ON_TICK=0 build.
module tb_frame_swap_scheduler;

    localparam int FW = 768;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          turn_tick, s_valid, s_sof, fc_req, fc_addr;
    logic [127:0]  s_data;
    logic [47:0]   fc_data;
    logic          s_ready, fc_ack, color_w_enable, fc_w_addr, fc_w_enable;
    logic          write_fc, new_frame, busy, err_restart, err_drop;
    logic [AW-1:0] color_w_addr;
    logic [127:0]  color_w_data;
    logic [47:0]   fc_w_data;

    logic          turn_tick0, s_valid0, s_sof0;
    logic [127:0]  s_data0;
    logic          s_ready0, fc_ack0, color_w_enable0, fc_w_addr0, fc_w_enable0;
    logic          write_fc0, new_frame0, busy0, err_restart0, err_drop0;
    logic [AW-1:0] color_w_addr0;
    logic [127:0]  color_w_data0;
    logic [47:0]   fc_w_data0;

    frame_swap_scheduler dut (
        .clk(clk), .rst(rst), .turn_tick(turn_tick),
        .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data), .s_ready(s_ready),
        .fc_req(fc_req), .fc_data(fc_data), .fc_addr(fc_addr), .fc_ack(fc_ack),
        .color_w_addr(color_w_addr), .color_w_data(color_w_data),
        .color_w_enable(color_w_enable),
        .fc_w_data(fc_w_data), .fc_w_addr(fc_w_addr), .fc_w_enable(fc_w_enable),
        .write_fc(write_fc), .new_frame(new_frame), .busy(busy),
        .err_restart(err_restart), .err_drop(err_drop)
    );

    frame_swap_scheduler #(.SWAP_ON_TICK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .turn_tick(turn_tick0),
        .s_valid(s_valid0), .s_sof(s_sof0), .s_data(s_data0), .s_ready(s_ready0),
        .fc_req(1'b0), .fc_data(48'h0), .fc_addr(1'b0), .fc_ack(fc_ack0),
        .color_w_addr(color_w_addr0), .color_w_data(color_w_data0),
        .color_w_enable(color_w_enable0),
        .fc_w_data(fc_w_data0), .fc_w_addr(fc_w_addr0), .fc_w_enable(fc_w_enable0),
        .write_fc(write_fc0), .new_frame(new_frame0), .busy(busy0),
        .err_restart(err_restart0), .err_drop(err_drop0)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int tick_cyc = 0;
    int nf_cyc = 0;
    int nf_cnt = 0, nf0_cnt = 0, er_cnt = 0, ed_cnt = 0, we_cnt = 0;
    logic [127:0] obs_mem [FW];
    logic [127:0] exp_mem [FW];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (color_w_enable === 1'b1) begin
            we_cnt++;
            if (int'(color_w_addr) < FW) obs_mem[color_w_addr] = color_w_data;
        end
        if (new_frame === 1'b1) begin
            nf_cnt++;
            nf_cyc = cyc;
        end
        if (new_frame0 === 1'b1) nf0_cnt++;
        if (err_restart === 1'b1) er_cnt++;
        if (err_drop === 1'b1) ed_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < FW; i++) obs_mem[i] = 'x;
    endtask

    task automatic load_words(input int n, input bit sof_first, input int base);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_sof   = sof_first && (i == 0);
            s_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp_mem[base + i] = s_data;
            step();
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic pulse_tick();
        turn_tick = 1'b1;
        tick_cyc  = cyc;
        step();
        step();
        step();
        turn_tick = 1'b0;
    endtask

    task automatic wait_nf(input int nf_before, output int delay);
        delay = -1;
        for (int i = 0; i < 40 && delay < 0; i++) begin
            @(negedge clk);
            #1;
            if (nf_cnt > nf_before) delay = nf_cyc - tick_cyc;
        end
        step();
    endtask

    function automatic int mem_bad();
        int bad = 0;
        for (int i = 0; i < FW; i++) if (obs_mem[i] !== exp_mem[i]) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({s_ready, busy, new_frame, color_w_enable, fc_ack, fc_w_enable, write_fc,
             err_restart, err_drop, fc_w_addr} !== 10'b0)
            $display("FAIL reset_ctrl: got %b expected 0", {s_ready, busy, new_frame,
                     color_w_enable, fc_ack, fc_w_enable, write_fc, err_restart, err_drop, fc_w_addr});
        else passed++;
        checks++;
        if ({color_w_addr, color_w_data, fc_w_data} !== '0)
            $display("FAIL reset_data: addr %0h data %0h fc %0h expected 0",
                     color_w_addr, color_w_data, fc_w_data);
        else passed++;
        checks++;
        if ({s_ready0, busy0, new_frame0} !== 3'b0)
            $display("FAIL reset_dut0: got %b expected 000", {s_ready0, busy0, new_frame0});
        else passed++;
        rst = 1'b1;
        step();
        checks++;
        if ({s_ready, busy} !== 2'b10)
            $display("FAIL reset_release: s_ready/busy %b expected 10", {s_ready, busy});
        else passed++;
    endtask

    task automatic test_full_frame();
        int nf_b, we_b, rdy_seen, d;
        clear_mem();
        nf_b = nf_cnt;
        load_words(FW, 1'b1, 0);
        checks++;
        if ({busy, s_ready} !== 2'b10)
            $display("FAIL wait_tick_state: busy/s_ready %b expected 10", {busy, s_ready});
        else passed++;
        we_b = we_cnt + 0;
        rdy_seen = 0;
        s_valid = 1'b1;
        s_sof   = 1'b0;
        s_data  = '1;
        for (int i = 0; i < 100; i++) begin
            if (s_ready !== 1'b0) rdy_seen++;
            step();
        end
        s_valid = 1'b0;
        checks++;
        if (rdy_seen !== 0) $display("FAIL wait_tick_ready: s_ready high %0d cycles expected 0", rdy_seen);
        else passed++;
        checks++;
        if (we_cnt - we_b !== 1)
            $display("FAIL wait_tick_nowrite: writes %0d expected 1 (last word only)", we_cnt - we_b);
        else passed++;
        checks++;
        if (nf_cnt !== nf_b) $display("FAIL early_swap: new_frame %0d expected %0d", nf_cnt, nf_b);
        else passed++;
        pulse_tick();
        wait_nf(nf_b, d);
        checks++;
        if (d < 3 || d > 4) $display("FAIL tick_latency: got %0d expected 3..4", d);
        else passed++;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (nf_cnt - nf_b !== 1) $display("FAIL swap_count: got %0d expected 1", nf_cnt - nf_b);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL swap_idle: busy %b expected 0", busy);
        else passed++;
        checks++;
        if (mem_bad() !== 0) $display("FAIL frame_mem: %0d bad words expected 0", mem_bad());
        else passed++;
    endtask

    task automatic test_abort();
        int er_b, nf_b, d;
        logic [127:0] w;
        clear_mem();
        er_b = er_cnt;
        nf_b = nf_cnt;
        load_words(300, 1'b1, 0);
        w       = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_mem[0] = w;
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_data  = w;
        step();
        checks++;
        if ({color_w_enable, color_w_addr, color_w_data, err_restart} !== {1'b1, 10'd0, w, 1'b1})
            $display("FAIL abort_word: en %b addr %0d data %0h err %b expected 1 0 %0h 1",
                     color_w_enable, color_w_addr, color_w_data, err_restart, w);
        else passed++;
        load_words(FW - 1, 1'b0, 1);
        step();
        checks++;
        if (er_cnt - er_b !== 1) $display("FAIL abort_err_count: got %0d expected 1", er_cnt - er_b);
        else passed++;
        checks++;
        if (nf_cnt !== nf_b) $display("FAIL abort_noswap: new_frame %0d expected %0d", nf_cnt, nf_b);
        else passed++;
        pulse_tick();
        wait_nf(nf_b, d);
        checks++;
        if (d < 3 || d > 4) $display("FAIL abort_latency: got %0d expected 3..4", d);
        else passed++;
        checks++;
        if (mem_bad() !== 0) $display("FAIL abort_mem: %0d bad words expected 0", mem_bad());
        else passed++;
    endtask

    task automatic test_drop();
        int ed_b, we_b, busy_seen;
        ed_b = ed_cnt;
        we_b = we_cnt;
        busy_seen = 0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_sof   = 1'b0;
            s_data  = {4{$urandom()}};
            step();
            if (busy !== 1'b0) busy_seen++;
        end
        s_valid = 1'b0;
        step();
        step();
        checks++;
        if (ed_cnt - ed_b !== 3) $display("FAIL drop_count: got %0d expected 3", ed_cnt - ed_b);
        else passed++;
        checks++;
        if (we_cnt - we_b !== 0) $display("FAIL drop_nowrite: writes %0d expected 0", we_cnt - we_b);
        else passed++;
        checks++;
        if (busy_seen !== 0) $display("FAIL drop_busy: busy seen %0d expected 0", busy_seen);
        else passed++;
    endtask

    task automatic test_fc();
        int nf_b, d;
        logic [127:0] w;
        clear_mem();
        nf_b    = nf_cnt;
        w       = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_mem[0] = w;
        fc_req  = 1'b1;
        fc_data = 48'h5c0201008048;
        fc_addr = 1'b1;
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_data  = w;
        #1;
        checks++;
        if (s_ready !== 1'b0) $display("FAIL fc_priority: s_ready %b expected 0", s_ready);
        else passed++;
        step();
        checks++;
        if ({fc_ack, fc_w_enable, fc_w_addr, fc_w_data, write_fc, color_w_enable} !==
            {1'b1, 1'b1, 1'b1, 48'h5c0201008048, 1'b0, 1'b0})
            $display("FAIL fc_write: ack %b en %b addr %b data %h strobe %b cwe %b expected 1 1 1 5c0201008048 0 0",
                     fc_ack, fc_w_enable, fc_w_addr, fc_w_data, write_fc, color_w_enable);
        else passed++;
        fc_req  = 1'b0;
        fc_data = '0;
        fc_addr = 1'b0;
        step();
        checks++;
        if ({write_fc, fc_ack, fc_w_enable} !== 3'b100)
            $display("FAIL fc_strobe: write_fc/ack/en %b expected 100", {write_fc, fc_ack, fc_w_enable});
        else passed++;
        step();
        checks++;
        if ({busy, s_ready} !== 2'b01)
            $display("FAIL fc_back_idle: busy/s_ready %b expected 01", {busy, s_ready});
        else passed++;
        step();
        checks++;
        if ({color_w_enable, color_w_addr, color_w_data} !== {1'b1, 10'd0, w})
            $display("FAIL fc_then_word: en %b addr %0d data %0h expected 1 0 %0h",
                     color_w_enable, color_w_addr, color_w_data, w);
        else passed++;
        load_words(FW - 1, 1'b0, 1);
        pulse_tick();
        wait_nf(nf_b, d);
        checks++;
        if (d < 3 || d > 4) $display("FAIL fc_frame_latency: got %0d expected 3..4", d);
        else passed++;
        checks++;
        if (mem_bad() !== 0) $display("FAIL fc_frame_mem: %0d bad words expected 0", mem_bad());
        else passed++;
    endtask

    task automatic test_no_tick_swap();
        int nf0_b;
        nf0_b = nf0_cnt;
        for (int i = 0; i < FW; i++) begin
            s_valid0 = 1'b1;
            s_sof0   = (i == 0);
            s_data0  = {4{$urandom()}};
            if (i == 100) turn_tick0 = 1'b1;
            if (i == 104) turn_tick0 = 1'b0;
            step();
        end
        s_valid0 = 1'b0;
        s_sof0   = 1'b0;
        checks++;
        if ({color_w_enable0, color_w_addr0, new_frame0} !== {1'b1, 10'd767, 1'b0})
            $display("FAIL nt_last_write: en %b addr %0d nf %b expected 1 767 0",
                     color_w_enable0, color_w_addr0, new_frame0);
        else passed++;
        checks++;
        if (nf0_cnt !== nf0_b) $display("FAIL nt_tick_in_load: new_frame %0d expected %0d", nf0_cnt, nf0_b);
        else passed++;
        step();
        checks++;
        if (new_frame0 !== 1'b1) $display("FAIL nt_swap_timing: new_frame %b expected 1", new_frame0);
        else passed++;
        step();
        checks++;
        if ({new_frame0, busy0} !== 2'b00)
            $display("FAIL nt_swap_end: new_frame/busy %b expected 00", {new_frame0, busy0});
        else passed++;
        checks++;
        if (nf0_cnt - nf0_b !== 1) $display("FAIL nt_swap_count: got %0d expected 1", nf0_cnt - nf0_b);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int nf_b, d;
        nf_b = nf_cnt;
        load_words(500, 1'b1, 0);
        s_valid = 1'b1;
        s_sof   = 1'b0;
        s_data  = '1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({s_ready, busy, new_frame, color_w_enable, fc_ack, fc_w_enable, write_fc,
             err_restart, err_drop} !== 9'b0)
            $display("FAIL rst_mid_ctrl: got %b expected 0", {s_ready, busy, new_frame,
                     color_w_enable, fc_ack, fc_w_enable, write_fc, err_restart, err_drop});
        else passed++;
        checks++;
        if ({color_w_addr, color_w_data} !== '0)
            $display("FAIL rst_mid_data: addr %0d data %0h expected 0", color_w_addr, color_w_data);
        else passed++;
        s_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        step();
        pulse_tick();
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (nf_cnt !== nf_b) $display("FAIL rst_mid_spurious: new_frame %0d expected %0d", nf_cnt, nf_b);
        else passed++;
        clear_mem();
        load_words(FW, 1'b1, 0);
        pulse_tick();
        wait_nf(nf_b, d);
        checks++;
        if (d < 3 || d > 4) $display("FAIL rst_mid_latency: got %0d expected 3..4", d);
        else passed++;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (nf_cnt - nf_b !== 1) $display("FAIL rst_mid_swaps: got %0d expected 1", nf_cnt - nf_b);
        else passed++;
        checks++;
        if (mem_bad() !== 0) $display("FAIL rst_mid_mem: %0d bad words expected 0", mem_bad());
        else passed++;
    endtask

    initial begin
        rst        = 1'b0;
        turn_tick  = 1'b0;
        s_valid    = 1'b0;
        s_sof      = 1'b0;
        s_data     = '0;
        fc_req     = 1'b0;
        fc_data    = '0;
        fc_addr    = 1'b0;
        turn_tick0 = 1'b0;
        s_valid0   = 1'b0;
        s_sof0     = 1'b0;
        s_data0    = '0;
        test_reset();
        test_full_frame();
        test_abort();
        test_drop();
        test_fc();
        test_no_tick_swap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
